// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of the multiplexed 7-segment scan bus.
// Rebuilds the six BCD digits (HH:MM:SS) from the scan stream, checks
// protocol integrity and publishes a time only after STABLE_FRAMES
// consecutive identical error-free frames.
//
// Ports:
//   clk          system clock, same domain as the scan source
//   rst          asynchronous active-low reset
//   seg_com      digit select, active-low one-cold (0xFF = blank)
//   seg_data     segment pattern {a,b,c,d,e,f,g,dp}, active-high
//   time_bcd     published {h_ten,h_one,m_ten,m_one,s_ten,s_one}
//   frame_valid  one-cycle pulse when time_bcd is updated
//   locked       published value backed by error-free frames
//   frame_err    one-cycle pulse on a protocol error
//   err_code     last error: 1 com, 2 segment, 3 sequence, 4 range
//
// Optional feature: define SEG_SCAN_RANGE_CHECK_EN to reject frames whose
// digits are not a legal 24-hour time (err_code 4).
module seg_scan_decoder #(
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_com,
  input  logic [7:0]  seg_data,
  output logic [23:0] time_bcd,
  output logic        frame_valid,
  output logic        locked,
  output logic        frame_err,
  output logic [2:0]  err_code
);

  localparam int unsigned SEGW  = 8;
  localparam int unsigned DIGW  = 4;
  localparam int unsigned NDIG  = 6;
  localparam int unsigned TIMEW = NDIG * DIGW;
  localparam int unsigned CNTW  = 4;
  localparam int unsigned EXPW  = 3;
  localparam int unsigned CODEW = 3;

  localparam logic [CNTW-1:0]  CNT_MAX  = '1;
  localparam logic [CNTW-1:0]  STABLE_N = CNTW'(STABLE_FRAMES);
  localparam logic [EXPW-1:0]  EXP_LAST = EXPW'(NDIG);
  localparam logic [CODEW-1:0] ERR_COM  = CODEW'(1);
  localparam logic [CODEW-1:0] ERR_SEG  = CODEW'(2);
  localparam logic [CODEW-1:0] ERR_SEQ  = CODEW'(3);
  localparam logic [CODEW-1:0] ERR_RNG  = CODEW'(4);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_GAP     = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  logic [SEGW-1:0]  r_com, r_data;
  state_t           r_state, w_state_nxt;
  logic [EXPW-1:0]  r_exp, w_exp_nxt;
  logic [TIMEW-1:0] r_frame, w_frame_nxt;
  logic [TIMEW-1:0] r_cand, w_cand_nxt;
  logic [TIMEW-1:0] r_time, w_time_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_fv, w_fv_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic [CODEW-1:0] r_code, w_code_nxt;

  logic             w_blank, w_com_err, w_seg_bad;
  logic [EXPW-1:0]  w_slot;
  logic [DIGW-1:0]  w_digit;
  logic             w_match, w_pub, w_range_bad;
  logic [CNTW-1:0]  w_cnt_new;
  logic             w_err, w_wr_en;
  logic [CODEW-1:0] w_err_code;
  logic [EXPW-1:0]  w_wr_slot;
  logic             w_unused_dp;

  // Input register; com resets to an illegal code so HUNT waits for a real blank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_com  <= '0;
      r_data <= '0;
    end else begin
      r_com  <= seg_com;
      r_data <= seg_data;
    end
  end

  assign w_unused_dp = r_data[0];

  // Slot decode from the one-cold digit select.
  always_comb begin
    w_blank   = 1'b0;
    w_com_err = 1'b0;
    w_slot    = '0;
    case (r_com)
      8'h7F:   w_slot = EXPW'(0);
      8'hBF:   w_slot = EXPW'(1);
      8'hDF:   w_slot = EXPW'(2);
      8'hEF:   w_slot = EXPW'(3);
      8'hF7:   w_slot = EXPW'(4);
      8'hFB:   w_slot = EXPW'(5);
      8'hFF:   w_blank = 1'b1;
      default: w_com_err = 1'b1;
    endcase
  end

  // Segment pattern to digit, decimal point excluded.
  always_comb begin
    w_seg_bad = 1'b0;
    w_digit   = '0;
    case (r_data[7:1])
      7'h7E:   w_digit = DIGW'(0);
      7'h30:   w_digit = DIGW'(1);
      7'h6D:   w_digit = DIGW'(2);
      7'h79:   w_digit = DIGW'(3);
      7'h33:   w_digit = DIGW'(4);
      7'h5B:   w_digit = DIGW'(5);
      7'h5F:   w_digit = DIGW'(6);
      7'h70:   w_digit = DIGW'(7);
      7'h7F:   w_digit = DIGW'(8);
      7'h7B:   w_digit = DIGW'(9);
      default: w_seg_bad = 1'b1;
    endcase
  end

  // Stability tracking for a completed frame.
  assign w_match   = (r_frame == r_cand);
  assign w_cnt_new = w_match ? ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNTW'(1))
                             : CNTW'(1);
  // Publish only on the transition into STABLE_N, not while sitting there.
  assign w_pub     = (w_cnt_new == STABLE_N) && !(w_match && (r_cnt == STABLE_N));

`ifdef SEG_SCAN_RANGE_CHECK_EN
  assign w_range_bad = (r_frame[23:20] > 4'd2) ||
                       ((r_frame[23:20] == 4'd2) && (r_frame[19:16] > 4'd3)) ||
                       (r_frame[15:12] > 4'd5) ||
                       (r_frame[7:4] > 4'd5);
`else
  assign w_range_bad = 1'b0;
`endif

  // State and publish registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_HUNT;
      r_exp    <= '0;
      r_frame  <= '0;
      r_cand   <= '0;
      r_time   <= '0;
      r_cnt    <= '0;
      r_fv     <= 1'b0;
      r_locked <= 1'b0;
      r_ferr   <= 1'b0;
      r_code   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_exp    <= w_exp_nxt;
      r_frame  <= w_frame_nxt;
      r_cand   <= w_cand_nxt;
      r_time   <= w_time_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fv     <= w_fv_nxt;
      r_locked <= w_locked_nxt;
      r_ferr   <= w_ferr_nxt;
      r_code   <= w_code_nxt;
    end
  end

  // Next-state, frame capture and publish logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_exp_nxt    = r_exp;
    w_frame_nxt  = r_frame;
    w_cand_nxt   = r_cand;
    w_time_nxt   = r_time;
    w_cnt_nxt    = r_cnt;
    w_fv_nxt     = 1'b0;
    w_locked_nxt = r_locked;
    w_ferr_nxt   = 1'b0;
    w_code_nxt   = r_code;
    w_err        = 1'b0;
    w_err_code   = '0;
    w_wr_en      = 1'b0;
    w_wr_slot    = w_slot;

    case (r_state)
      S_HUNT: begin
        if (w_blank) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_com_err) begin
          w_err = 1'b1; w_err_code = ERR_COM;
        end else if (w_blank) begin
          w_state_nxt = S_GAP;
        end else if (w_seg_bad) begin
          w_err = 1'b1; w_err_code = ERR_SEG;
        end else if (w_slot == EXPW'(0)) begin
          w_wr_en     = 1'b1;
          w_exp_nxt   = EXPW'(1);
          w_state_nxt = S_CAPTURE;
        end else begin
          w_err = 1'b1; w_err_code = ERR_SEQ;
        end
      end
      S_CAPTURE: begin
        if (w_com_err) begin
          w_err = 1'b1; w_err_code = ERR_COM;
        end else if (w_blank) begin
          if (r_exp != EXP_LAST) begin
            w_err = 1'b1; w_err_code = ERR_SEQ;
          end else if (w_range_bad) begin
            w_err = 1'b1; w_err_code = ERR_RNG;
          end else begin
            w_state_nxt = S_GAP;
            w_cand_nxt  = r_frame;
            w_cnt_nxt   = w_cnt_new;
            if (w_pub) begin
              w_time_nxt   = r_frame;
              w_fv_nxt     = 1'b1;
              w_locked_nxt = 1'b1;
            end
          end
        end else if (w_seg_bad) begin
          w_err = 1'b1; w_err_code = ERR_SEG;
        end else if (w_slot == r_exp - EXPW'(1)) begin
          w_wr_en = 1'b1;
        end else if (w_slot == r_exp) begin
          w_wr_en   = 1'b1;
          w_exp_nxt = r_exp + EXPW'(1);
        end else begin
          w_err = 1'b1; w_err_code = ERR_SEQ;
        end
      end
      default: w_state_nxt = S_HUNT;
    endcase

    // Slot 0 lands in the most significant nibble.
    for (int i = 0; i < int'(NDIG); i++) begin
      if (w_wr_en && (w_wr_slot == EXPW'(i)))
        w_frame_nxt[TIMEW-1-DIGW*i -: DIGW] = w_digit;
    end

    if (w_err) begin
      w_ferr_nxt   = 1'b1;
      w_code_nxt   = w_err_code;
      w_locked_nxt = 1'b0;
      w_cnt_nxt    = '0;
      w_state_nxt  = S_HUNT;
    end
  end

  assign time_bcd    = r_time;
  assign frame_valid = r_fv;
  assign locked      = r_locked;
  assign frame_err   = r_ferr;
  assign err_code    = r_code;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench for seg_scan_decoder.
// Expected publish/error events are queued with their due cycle when the
// frame-ending or offending scan word is driven, and popped when the DUT
// pulses frame_valid or frame_err.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  seg_com = 8'hFF;
  logic [7:0]  seg_data = 8'h00;
  logic [23:0] time_bcd;
  logic        frame_valid, locked, frame_err;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .seg_com     (seg_com),
    .seg_data    (seg_data),
    .time_bcd    (time_bcd),
    .frame_valid (frame_valid),
    .locked      (locked),
    .frame_err   (frame_err),
    .err_code    (err_code)
  );

  typedef struct {
    bit          is_err;
    logic [23:0] val;
    int          at;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  logic [7:0] com_tab [6];
  logic [7:0] seg_tab [10];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic drive(input logic [7:0] com, input logic [7:0] data);
    @(negedge clk);
    seg_com  = com;
    seg_data = data;
  endtask

  task automatic blank();
    drive(8'hFF, 8'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) blank();
  endtask

  // Expected event is due two edges after the word now on the inputs.
  task automatic push(input bit is_err, input logic [23:0] val);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    e.at     = cyc + 2;
    sb_q.push_back(e);
  endtask

  task automatic send_digit(input int slot, input logic [3:0] d, input int hold);
    repeat (hold) drive(com_tab[slot], seg_tab[d] | 8'($urandom_range(0, 1)));
  endtask

  // mode: 0 no event, 1 publish expected, 2 range error expected
  task automatic send_frame(input logic [23:0] t, input int hold, input int gap, input int mode);
    for (int i = 0; i < 6; i++) send_digit(i, t[23-4*i -: 4], hold);
    blank();
    if (mode == 1) push(1'b0, t);
    if (mode == 2) push(1'b1, 24'd4);
    idle(gap - 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_time"},   32'(time_bcd),    32'h0);
    chk({tag, "_valid"},  32'(frame_valid), 32'h0);
    chk({tag, "_locked"}, 32'(locked),      32'h0);
    chk({tag, "_ferr"},   32'(frame_err),   32'h0);
    chk({tag, "_code"},   32'(err_code),    32'h0);
  endtask

  // Output monitor: pops the scoreboard on every pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (frame_valid) begin
        if (sb_q.size() == 0) chk("spurious_valid", 32'(frame_valid), 32'h0);
        else begin
          e = sb_q.pop_front();
          chk("valid_kind",  32'(e.is_err),  32'h0);
          chk("valid_time",  32'(time_bcd),  32'(e.val));
          chk("valid_cycle", 32'(cyc),       32'(e.at));
        end
      end
      if (frame_err) begin
        if (sb_q.size() == 0) chk("spurious_err", 32'(frame_err), 32'h0);
        else begin
          e = sb_q.pop_front();
          chk("err_kind",  32'(e.is_err),   32'h1);
          chk("err_code",  32'(err_code),   32'(e.val[2:0]));
          chk("err_cycle", 32'(cyc),        32'(e.at));
        end
      end
    end
  end

  initial begin
    com_tab = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB};
    seg_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(3);

    // Two identical frames publish 12:34:56
    send_frame(24'h123456, 1, 2, 0);
    send_frame(24'h123456, 1, 2, 1);
    idle(2);
    chk("pub1_time",   32'(time_bcd), 32'h123456);
    chk("pub1_locked", 32'(locked),   32'h1);
    // A third identical frame must not pulse again
    send_frame(24'h123456, 1, 2, 0);
    idle(2);
    chk("pub1_hold_locked", 32'(locked), 32'h1);

    // Illegal segment pattern on slot 3
    send_digit(0, 4'd1, 1);
    send_digit(1, 4'd2, 1);
    send_digit(2, 4'd3, 1);
    drive(com_tab[3], 8'h12);
    push(1'b1, 24'd2);
    idle(3);
    chk("seg_err_code",   32'(err_code), 32'h2);
    chk("seg_err_locked", 32'(locked),   32'h0);
    chk("seg_err_time",   32'(time_bcd), 32'h123456);
    send_frame(24'h123457, 1, 2, 0);
    send_frame(24'h123457, 1, 2, 1);
    idle(2);
    chk("pub2_time",   32'(time_bcd), 32'h123457);
    chk("pub2_locked", 32'(locked),   32'h1);

    // Slot order 0,1,3
    send_digit(0, 4'd1, 1);
    send_digit(1, 4'd2, 1);
    send_digit(3, 4'd4, 1);
    push(1'b1, 24'd3);
    idle(3);
    chk("seq_err_code",   32'(err_code), 32'h3);
    chk("seq_err_locked", 32'(locked),   32'h0);

    // Illegal com value in CAPTURE
    send_digit(0, 4'd1, 1);
    drive(8'h3F, seg_tab[5]);
    push(1'b1, 24'd1);
    idle(3);
    chk("com_err_code", 32'(err_code), 32'h1);
    chk("com_err_time", 32'(time_bcd), 32'h123457);

    // Slow scan: each slot held 3 cycles, 4-cycle blank gap
    send_frame(24'h235959, 3, 4, 0);
    send_frame(24'h235959, 3, 4, 1);
    idle(2);
    chk("slow_time",   32'(time_bcd), 32'h235959);
    chk("slow_locked", 32'(locked),   32'h1);
    chk("slow_code",   32'(err_code), 32'h1);

    // Reset asserted during slot 2
    chk("pre_rst_pending", 32'(sb_q.size()), 32'h0);
    send_digit(0, 4'd0, 1);
    send_digit(1, 4'd1, 1);
    drive(com_tab[2], seg_tab[3]);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    drive(com_tab[2], seg_tab[3]);
    rst_n = 1'b1;
    send_digit(3, 4'd4, 1);
    send_digit(4, 4'd5, 1);
    send_digit(5, 4'd6, 1);
    idle(2);
    send_frame(24'h123456, 1, 2, 0);
    idle(2);
    chk("rst_first_time",   32'(time_bcd), 32'h0);
    chk("rst_first_locked", 32'(locked),   32'h0);
    send_frame(24'h123456, 1, 2, 1);
    idle(2);
    chk("rst_second_time",   32'(time_bcd), 32'h123456);
    chk("rst_second_locked", 32'(locked),   32'h1);

    // 25:00:00 frames
`ifdef SEG_SCAN_RANGE_CHECK_EN
    send_frame(24'h250000, 1, 2, 2);
    send_frame(24'h250000, 1, 2, 2);
    idle(2);
    chk("range_time",   32'(time_bcd), 32'h123456);
    chk("range_code",   32'(err_code), 32'h4);
    chk("range_locked", 32'(locked),   32'h0);
`else
    send_frame(24'h250000, 1, 2, 0);
    send_frame(24'h250000, 1, 2, 1);
    idle(2);
    chk("norange_time",   32'(time_bcd), 32'h250000);
    chk("norange_locked", 32'(locked),   32'h1);
    chk("norange_code",   32'(err_code), 32'h0);
`endif

    idle(4);
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
